// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes and data-memory waits with timeout.
// Optional perf counters enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned WAIT_TIMEOUT   = 16,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
    input  logic                      IF_ID_uses_rs1,
    input  logic                      IF_ID_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
    input  logic                      ID_EX_mem_read,
    input  logic                      ex_branch_taken,
    input  logic                      dmem_req,
    input  logic                      dmem_ready,
    output logic                      pc_write_en,
    output logic                      IF_ID_write_en,
    output logic                      IF_ID_flush,
    output logic                      ctr_sel,
    output logic                      pipe_hold,
    output logic                      mem_timeout,
    output logic [1:0]                ctrl_state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0]      perf_lu_stalls,
    output logic [CNT_WIDTH-1:0]      perf_flushes,
    output logic [CNT_WIDTH-1:0]      perf_mem_wait_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(WAIT_TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] wait_q, wait_d;
    logic                 timeout_q, timeout_d;

    logic mem_busy;
    logic load_use;
    logic eval_hz;
    logic pc_c, ifid_we_c, flush_c, ctr_c, hold_c, lu_stall_c;

    assign mem_busy = dmem_req & ~dmem_ready;
    assign load_use = ID_EX_mem_read & (ID_EX_rd != '0) &
                      ((IF_ID_uses_rs1 & (IF_ID_rs1 == ID_EX_rd)) |
                       (IF_ID_uses_rs2 & (IF_ID_rs2 == ID_EX_rd)));

    // Next-state and same-cycle pipeline controls
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        timeout_d  = timeout_q;
        pc_c       = 1'b1;
        ifid_we_c  = 1'b1;
        flush_c    = 1'b0;
        ctr_c      = 1'b1;
        hold_c     = 1'b0;
        lu_stall_c = 1'b0;
        eval_hz    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    hold_c    = 1'b1;
                    pc_c      = 1'b0;
                    ifid_we_c = 1'b0;
                    state_d   = ST_MEM_WAIT;
                    wait_d    = CNT_ONE;
                end else begin
                    eval_hz = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!dmem_ready) begin
                    hold_c    = 1'b1;
                    pc_c      = 1'b0;
                    ifid_we_c = 1'b0;
                    wait_d    = (wait_q == CNT_MAX) ? wait_q : wait_q + CNT_ONE;
                    if (wait_q == TIMEOUT_LAST) begin
                        state_d   = ST_ERROR;
                        timeout_d = 1'b1;
                    end
                end else begin
                    eval_hz = 1'b1;
                    state_d = ST_RUN;
                    wait_d  = '0;
                end
            end
            ST_ERROR: begin
                hold_c    = 1'b1;
                pc_c      = 1'b0;
                ifid_we_c = 1'b0;
                ctr_c     = 1'b0;
                timeout_d = 1'b1;
            end
            default: begin
                hold_c    = 1'b1;
                pc_c      = 1'b0;
                ifid_we_c = 1'b0;
                ctr_c     = 1'b0;
                state_d   = ST_RUN;
                wait_d    = '0;
            end
        endcase

        // A taken branch kills both younger instructions, so it overrides a load-use stall
        if (eval_hz) begin
            if (ex_branch_taken) begin
                flush_c = 1'b1;
                ctr_c   = 1'b0;
            end else if (load_use) begin
                pc_c       = 1'b0;
                ifid_we_c  = 1'b0;
                ctr_c      = 1'b0;
                lu_stall_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    // Controls are forced inactive while reset is asserted
    assign pc_write_en    = reset_n & pc_c;
    assign IF_ID_write_en = reset_n & ifid_we_c;
    assign IF_ID_flush    = reset_n & flush_c;
    assign ctr_sel        = reset_n & ctr_c;
    assign pipe_hold      = reset_n & hold_c;
    assign mem_timeout    = timeout_q;
    assign ctrl_state     = state_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [CNT_WIDTH-1:0] perf_lu_q, perf_fl_q, perf_wt_q;

    // Saturating event counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_lu_q <= '0;
            perf_fl_q <= '0;
            perf_wt_q <= '0;
        end else begin
            if (lu_stall_c && perf_lu_q != CNT_MAX) perf_lu_q <= perf_lu_q + CNT_ONE;
            if (flush_c && perf_fl_q != CNT_MAX)    perf_fl_q <= perf_fl_q + CNT_ONE;
            if (hold_c && perf_wt_q != CNT_MAX)     perf_wt_q <= perf_wt_q + CNT_ONE;
        end
    end

    assign perf_lu_stalls       = perf_lu_q;
    assign perf_flushes         = perf_fl_q;
    assign perf_mem_wait_cycles = perf_wt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a cycle model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned RAW = 5;
    localparam int unsigned WT  = 16;
    localparam int unsigned CW  = 16;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [RAW-1:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd;
    logic           IF_ID_uses_rs1, IF_ID_uses_rs2, ID_EX_mem_read;
    logic           ex_branch_taken, dmem_req, dmem_ready;
    logic           pc_write_en, IF_ID_write_en, IF_ID_flush, ctr_sel, pipe_hold, mem_timeout;
    logic [1:0]     ctrl_state;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [CW-1:0]  perf_lu_stalls, perf_flushes, perf_mem_wait_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    // Model state: mode 0 = running, 1 = waiting on memory, 2 = timed out
    int m_mode, m_waited, m_lu, m_fl, m_wt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_ADDR_WIDTH(RAW), .WAIT_TIMEOUT(WT), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
        .IF_ID_uses_rs1(IF_ID_uses_rs1), .IF_ID_uses_rs2(IF_ID_uses_rs2),
        .ID_EX_rd(ID_EX_rd), .ID_EX_mem_read(ID_EX_mem_read),
        .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write_en(pc_write_en), .IF_ID_write_en(IF_ID_write_en), .IF_ID_flush(IF_ID_flush),
        .ctr_sel(ctr_sel), .pipe_hold(pipe_hold), .mem_timeout(mem_timeout),
        .ctrl_state(ctrl_state)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        , .perf_lu_stalls(perf_lu_stalls), .perf_flushes(perf_flushes),
        .perf_mem_wait_cycles(perf_mem_wait_cycles)
`endif
    );

    // {pc_write_en, IF_ID_write_en, IF_ID_flush, ctr_sel, pipe_hold, ctrl_state, mem_timeout}
    function automatic logic [7:0] obs();
        return {pc_write_en, IF_ID_write_en, IF_ID_flush, ctr_sel, pipe_hold, ctrl_state, mem_timeout};
    endfunction

    function automatic logic [4:0] model_out();
        bit busy, lu;
        lu = ID_EX_mem_read && (ID_EX_rd != 0) &&
             ((IF_ID_uses_rs1 && IF_ID_rs1 == ID_EX_rd) || (IF_ID_uses_rs2 && IF_ID_rs2 == ID_EX_rd));
        if (m_mode == 2) return 5'b00001;
        busy = (m_mode == 0) ? (dmem_req && !dmem_ready) : !dmem_ready;
        if (busy)            return 5'b00011;
        if (ex_branch_taken) return 5'b11100;
        if (lu)              return 5'b00000;
        return 5'b11010;
    endfunction

    function automatic logic [7:0] model_exp();
        return {model_out(), 2'(m_mode), (m_mode == 2)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_waited = 0; m_lu = 0; m_fl = 0; m_wt = 0;
    endtask

    task automatic model_advance();
        logic [4:0] e;
        e = model_out();
        if (e[0]) m_wt++;
        if (e[2]) m_fl++;
        if (e == 5'b00000) m_lu++;
        if (m_mode == 0) begin
            if (dmem_req && !dmem_ready) begin m_mode = 1; m_waited = 1; end
        end else if (m_mode == 1) begin
            if (dmem_ready) begin
                m_mode = 0; m_waited = 0;
            end else begin
                m_waited++;
                if (m_waited >= WT) m_mode = 2;
            end
        end
    endtask

    task automatic set_in(input int rs1, input int rs2, input bit u1, input bit u2, input int rd,
                          input bit mr, input bit br, input bit req, input bit rdy);
        IF_ID_rs1 = RAW'(rs1); IF_ID_rs2 = RAW'(rs2);
        IF_ID_uses_rs1 = u1; IF_ID_uses_rs2 = u2;
        ID_EX_rd = RAW'(rd); ID_EX_mem_read = mr;
        ex_branch_taken = br; dmem_req = req; dmem_ready = rdy;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Advance one clock: model follows the edge, returns at the next falling edge
    task automatic tick();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        idle();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        set_in(5, 5, 1, 1, 5, 1, 1, 1, 0);
        model_reset();
        #1;
        checks++;
        if (obs() !== 8'h00) begin failures++; $display("FAIL reset_outputs got=%b exp=%b", obs(), 8'h00); end
        @(negedge clk);
        #1;
        checks++;
        if (obs() !== 8'h00) begin failures++; $display("FAIL reset_held got=%b exp=%b", obs(), 8'h00); end
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        #1;
        checks++;
        if (obs() !== 8'b11010_00_0) begin failures++; $display("FAIL reset_release got=%b exp=%b", obs(), 8'b11010_00_0); end
        tick();
    endtask

    task automatic test_load_use();
        set_in(0, 5, 0, 1, 5, 1, 0, 0, 1);
        #1;
        checks++;
        if (obs() !== 8'b00000_00_0) begin failures++; $display("FAIL lu_stall got=%b exp=%b", obs(), 8'b00000_00_0); end
        tick();
        idle();
        #1;
        checks++;
        if (obs() !== 8'b11010_00_0) begin failures++; $display("FAIL lu_one_cycle got=%b exp=%b", obs(), 8'b11010_00_0); end
        tick();
        set_in(0, 0, 0, 1, 0, 1, 0, 0, 1);
        #1;
        checks++;
        if (obs() !== 8'b11010_00_0) begin failures++; $display("FAIL lu_rd_zero got=%b exp=%b", obs(), 8'b11010_00_0); end
        tick();
        set_in(7, 3, 1, 0, 7, 1, 0, 0, 1);
        #1;
        checks++;
        if (obs() !== 8'b00000_00_0) begin failures++; $display("FAIL lu_rs1 got=%b exp=%b", obs(), 8'b00000_00_0); end
        tick();
        set_in(7, 3, 0, 1, 7, 1, 0, 0, 1);
        #1;
        checks++;
        if (obs() !== 8'b11010_00_0) begin failures++; $display("FAIL lu_unused_rs1 got=%b exp=%b", obs(), 8'b11010_00_0); end
        tick();
    endtask

    task automatic test_branch();
        set_in(0, 5, 0, 1, 5, 1, 1, 0, 1);
        #1;
        checks++;
        if (obs() !== 8'b11100_00_0) begin failures++; $display("FAIL branch_over_lu got=%b exp=%b", obs(), 8'b11100_00_0); end
        tick();
        idle();
        #1;
        checks++;
        if (obs() !== 8'b11010_00_0) begin failures++; $display("FAIL branch_after got=%b exp=%b", obs(), 8'b11010_00_0); end
        tick();
    endtask

    task automatic test_mem_wait();
        logic [7:0] exp;
        for (int c = 0; c < 3; c++) begin
            set_in(0, 5, 0, 1, 5, 1, c == 1, 1, 0);
            exp = {5'b00011, (c == 0) ? 2'd0 : 2'd1, 1'b0};
            #1;
            checks++;
            if (obs() !== exp) begin failures++; $display("FAIL mem_wait_hold c=%0d got=%b exp=%b", c, obs(), exp); end
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        #1;
        checks++;
        if (obs() !== 8'b11010_01_0) begin failures++; $display("FAIL mem_wait_release got=%b exp=%b", obs(), 8'b11010_01_0); end
        tick();
        idle();
        #1;
        checks++;
        if (obs() !== 8'b11010_00_0) begin failures++; $display("FAIL mem_wait_back_run got=%b exp=%b", obs(), 8'b11010_00_0); end
        tick();
    endtask

    task automatic test_timeout();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int c = 0; c < 5; c++) tick();
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs() !== 8'h00) begin failures++; $display("FAIL async_reset_mid_wait got=%b exp=%b", obs(), 8'h00); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            #1;
            checks++;
            if (ctrl_state !== ((c == 1) ? 2'd0 : 2'd1) || mem_timeout !== 1'b0) begin
                failures++;
                $display("FAIL timeout_pre c=%0d got=%0d/%b", c, ctrl_state, mem_timeout);
            end
            tick();
        end
        #1;
        checks++;
        if (obs() !== 8'b00001_10_1) begin failures++; $display("FAIL timeout_error got=%b exp=%b", obs(), 8'b00001_10_1); end
        set_in(0, 5, 0, 1, 5, 1, 1, 0, 1);
        for (int c = 0; c < 4; c++) tick();
        #1;
        checks++;
        if (obs() !== 8'b00001_10_1) begin failures++; $display("FAIL timeout_sticky got=%b exp=%b", obs(), 8'b00001_10_1); end
        do_reset();
        #1;
        checks++;
        if (obs() !== 8'b11010_00_0) begin failures++; $display("FAIL timeout_cleared got=%b exp=%b", obs(), 8'b11010_00_0); end
        tick();
    endtask

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    task automatic test_perf();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            set_in(5, 0, 1, 0, 5, 1, 0, 0, 1); tick();
            idle(); tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 1); tick();
        for (int k = 0; k < 4; k++) begin set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); tick(); end
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
        idle();
        #1;
        checks++;
        if (perf_lu_stalls !== CW'(2) || perf_flushes !== CW'(1) || perf_mem_wait_cycles !== CW'(4)) begin
            failures++;
            $display("FAIL perf_counts got=%0d/%0d/%0d exp=2/1/4", perf_lu_stalls, perf_flushes, perf_mem_wait_cycles);
        end
        tick();
    endtask
`endif

    task automatic test_random();
        bit slow;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            slow = ((i / 250) % 2) == 1;
            if ($urandom_range(0, 99) == 0) begin
                reset_n = 1'b0;
                model_reset();
                #1;
                checks++;
                if (obs() !== 8'h00) begin failures++; $display("FAIL rand_reset i=%0d got=%b", i, obs()); end
                @(negedge clk);
                reset_n = 1'b1;
            end
            set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3) == 0,
                   1'($urandom), slow ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) != 0));
            #1;
            checks++;
            if (obs() !== model_exp()) begin
                failures++;
                $display("FAIL rand_ctrl i=%0d got=%b exp=%b", i, obs(), model_exp());
            end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
            checks++;
            if (perf_lu_stalls !== CW'(m_lu) || perf_flushes !== CW'(m_fl) || perf_mem_wait_cycles !== CW'(m_wt)) begin
                failures++;
                $display("FAIL rand_perf i=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i,
                         perf_lu_stalls, perf_flushes, perf_mem_wait_cycles, m_lu, m_fl, m_wt);
            end
`endif
            tick();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        model_reset();
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        test_perf();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core.
- Sits beside the ID stage and generates the enables, flush and bubble controls for the PC, the IF/ID register and the ID/EX register (ctr_sel), plus a global hold for the downstream stage registers.
- Handles three events: load-use stalls, taken-branch flushes, and data-memory wait states with timeout detection.

Parameters:
- REG_ADDR_WIDTH, 5, register address width.
- WAIT_TIMEOUT, 16, number of consecutive memory-wait cycles that triggers a timeout error (minimum 2).
- CNT_WIDTH, 16, width of the wait counter and the perf counters.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- IF_ID_rs1  in  REG_ADDR_WIDTH  rs1 of the instruction in ID
- IF_ID_rs2  in  REG_ADDR_WIDTH  rs2 of the instruction in ID
- IF_ID_uses_rs1  in  1  instruction in ID reads rs1
- IF_ID_uses_rs2  in  1  instruction in ID reads rs2
- ID_EX_rd  in  REG_ADDR_WIDTH  rd of the instruction in EX
- ID_EX_mem_read  in  1  instruction in EX is a load
- ex_branch_taken  in  1  EX resolved a taken branch or jump (pc_sel)
- dmem_req  in  1  MEM stage has an active data-memory access
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write_en  out  1  PC update enable
- IF_ID_write_en  out  1  IF/ID load enable
- IF_ID_flush  out  1  IF/ID loads a NOP
- ctr_sel  out  1  1 = pass ID controls into ID/EX, 0 = insert bubble
- pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB
- mem_timeout  out  1  sticky error flag
- ctrl_state  out  2  current FSM state

Behaviour:
- Reset and clocking: clk and reset_n as already decided (asynchronous, active-low reset_n; clock clk).
- While reset_n is low:
  - state = RUN (2'd0); wait_cnt = 0; mem_timeout = 0.
  - Outputs forced to pc_write_en=0, IF_ID_write_en=0, IF_ID_flush=0, ctr_sel=0, pipe_hold=0.
- Outputs are combinational from the registered state and the current inputs, so the same-cycle reaction to a hazard has zero latency.
- Internal signals:
  - mem_busy = dmem_req & ~dmem_ready.
  - load_use = ID_EX_mem_read & (ID_EX_rd != 0) & ((IF_ID_uses_rs1 & IF_ID_rs1 == ID_EX_rd) | (IF_ID_uses_rs2 & IF_ID_rs2 == ID_EX_rd)).
- Default (RUN, no event): pc_write_en=1, IF_ID_write_en=1, IF_ID_flush=0, ctr_sel=1, pipe_hold=0.
- States: RUN=0, MEM_WAIT=1, ERROR=2. Encoding 3 is unused and recovers to RUN on the next clock.
- RUN, priority order (highest first):
  1. mem_busy: pipe_hold=1, pc_write_en=0, IF_ID_write_en=0, ctr_sel=1. Next state MEM_WAIT, wait_cnt <= 1.
  2. ex_branch_taken: pc_write_en=1, IF_ID_flush=1, IF_ID_write_en=1, ctr_sel=0. This kills both younger instructions; a simultaneous load_use is ignored.
  3. load_use: pc_write_en=0, IF_ID_write_en=0, ctr_sel=0 for exactly one cycle. The bubble clears ID_EX_mem_read, so the stall self-terminates.
- MEM_WAIT:
  - If dmem_ready=0: hold outputs as in RUN case 1; wait_cnt increments.
  - If wait_cnt == WAIT_TIMEOUT-1 and dmem_ready=0: next state ERROR, mem_timeout <= 1.
  - If dmem_ready=1: default outputs this cycle (pipeline advances); branch and load_use are evaluated with RUN priority; next state RUN; wait_cnt <= 0.
  - ex_branch_taken and load_use are ignored while held; EX is frozen, so a pending branch re-presents after release.
- ERROR: pipe_hold=1; pc_write_en=0; IF_ID_write_en=0; ctr_sel=0; mem_timeout=1. Only exits on reset.
- wait_cnt saturates and never wraps.
- Reset asserted mid-wait returns asynchronously to RUN with counters cleared.

Optional Feature:
- Macro: PIPE_HAZARD_CTRL_PERF_EN.
- When defined:
  - Adds outputs perf_lu_stalls, perf_flushes and perf_mem_wait_cycles, each CNT_WIDTH bits and saturating.
  - They count load_use stall cycles, branch flush events and pipe_hold cycles respectively.
  - All three reset to 0.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset with inputs active, then release -> all outputs 0 during reset; after release with idle inputs: pc_write_en=1, IF_ID_write_en=1, ctr_sel=1, ctrl_state=0.
- ID_EX_mem_read=1, ID_EX_rd=5, IF_ID_rs2=5, uses_rs2=1 for one cycle -> pc_write_en=0, IF_ID_write_en=0, ctr_sel=0 in that cycle only. Same stimulus with rd=0 -> no stall.
- ex_branch_taken=1 together with a load_use condition -> IF_ID_flush=1, ctr_sel=0, pc_write_en=1, no stall.
- dmem_req=1, dmem_ready=0 for 3 cycles then ready=1 -> pipe_hold=1 for 3 cycles, ctrl_state=1 during the wait, RUN with pipe_hold=0 on the ready cycle; ex_branch_taken pulsed mid-wait produces no flush.
- dmem_req=1, dmem_ready=0 held for 16 cycles -> ctrl_state=2 and mem_timeout=1 from cycle 16, both held until reset_n pulses low.
- With PIPE_HAZARD_CTRL_PERF_EN defined, 2 load-use stalls, 1 flush and a 4-cycle wait -> perf counters read 2, 1 and 4.
